// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel produces a square wave with period 2*(H+1) clk cycles plus a
// one-cycle tick on every rising edge. Half-period changes on a running
// channel are held pending and take effect at the next output toggle, so no
// half-cycle is ever truncated or stretched.
module clk_div_multi #(
    parameter int unsigned      CNT_W    = 26,
    parameter int unsigned      NCH      = 4,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(24_999_999),
    parameter int unsigned      CH_W     = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    logic [CNT_W-1:0] cnt_q    [NCH];
    logic [CNT_W-1:0] cnt_d    [NCH];
    logic [CNT_W-1:0] act_q    [NCH];
    logic [CNT_W-1:0] act_d    [NCH];
    logic [CNT_W-1:0] pend_h_q [NCH];
    logic [CNT_W-1:0] pend_h_d [NCH];
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   out_q, out_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   wr;

    // Config handshake decode; out-of-range channels always read as ready
    // and match no channel, so their writes are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend_q[i];
                wr[i]     = cfg_valid & ~pend_q[i];
            end
        end
    end

    // Per-channel next state: count, toggle, and apply pending half-periods.
    always_comb begin
        cnt_d    = cnt_q;
        act_d    = act_q;
        pend_h_d = pend_h_q;
        pend_d   = pend_q;
        out_d    = out_q;
        tick_d   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!en[i]) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
                if (pend_q[i]) begin
                    act_d[i]  = pend_h_q[i];
                    pend_d[i] = 1'b0;
                end
                // A write is only accepted with pend clear, so it cannot
                // collide with the pending apply above.
                if (wr[i]) begin
                    act_d[i] = cfg_half;
                end
            end else begin
                if (cnt_q[i] == act_q[i]) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = ~out_q[i];
                    tick_d[i] = ~out_q[i];
                    if (pend_q[i]) begin
                        act_d[i]  = pend_h_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                // A write landing on a toggle edge is deferred to the next one.
                if (wr[i]) begin
                    pend_h_d[i] = cfg_half;
                    pend_d[i]   = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q    <= '{default: '0};
            act_q    <= '{default: DEF_HALF};
            pend_h_q <= '{default: '0};
            pend_q   <= '0;
            out_q    <= '0;
            tick_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pend_h_q <= pend_h_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEF_HALF = 1 and a 3-bit channel
// select so that out-of-range channel numbers can be exercised.
module tb_clk_div_multi;

    localparam int unsigned      CNT_W    = 26;
    localparam int unsigned      NCH      = 4;
    localparam int unsigned      CH_W     = 3;
    localparam logic [CNT_W-1:0] DEF_HALF = 1;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic [NCH-1:0]   en = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int errors = 0;
    int checks = 0;

    clk_div_multi #(
        .CNT_W    (CNT_W),
        .NCH      (NCH),
        .DEF_HALF (DEF_HALF),
        .CH_W     (CH_W)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Park a channel, write its half-period directly, then re-enable it so the
    // next edge is edge 1 of a fresh count.
    task automatic load_direct(input int ch, input logic [CNT_W-1:0] h);
        en[ch] = 1'b0;
        step();
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_half  = h;
        step();
        cfg_valid = 1'b0;
        en[ch]    = 1'b1;
    endtask

    task automatic test_reset();
        logic eo, et;
        clr_n = 1'b0;
        en    = '0;
        repeat (2) step();
        checks++;
        if (clk_out !== '0) begin
            errors++; $display("FAIL reset_clk_out got=%b exp=0000", clk_out);
        end
        checks++;
        if (tick !== '0) begin
            errors++; $display("FAIL reset_tick got=%b exp=0000", tick);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready);
        end
        en    = '1;
        clr_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            eo = (e % 4 == 2) || (e % 4 == 3);
            et = (e % 4 == 2);
            checks++;
            if (clk_out !== {NCH{eo}}) begin
                errors++; $display("FAIL def_clk_out e=%0d got=%b exp=%b", e, clk_out, {NCH{eo}});
            end
            checks++;
            if (tick !== {NCH{et}}) begin
                errors++; $display("FAIL def_tick e=%0d got=%b exp=%b", e, tick, {NCH{et}});
            end
        end
    endtask

    // Writes to channel numbers >= NCH are ready and must not reach any channel.
    task automatic test_cfg_range();
        logic eo;
        cfg_ch    = 3'd5;
        cfg_half  = '0;
        cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL range_ready got=%b exp=1", cfg_ready);
        end
        for (int e = 9; e <= 11; e++) begin
            step();
            cfg_valid = 1'b0;
            eo = (e % 4 == 2) || (e % 4 == 3);
            checks++;
            if (clk_out !== {NCH{eo}}) begin
                errors++; $display("FAIL range_clk_out e=%0d got=%b exp=%b", e, clk_out, {NCH{eo}});
            end
        end
    endtask

    task automatic test_disabled_write();
        logic eo;
        load_direct(0, '0);
        for (int e = 1; e <= 6; e++) begin
            step();
            eo = (e % 2 == 1);
            checks++;
            if (clk_out[0] !== eo) begin
                errors++; $display("FAIL dis_wr_clk_out e=%0d got=%b exp=%b", e, clk_out[0], eo);
            end
            checks++;
            if (tick[0] !== eo) begin
                errors++; $display("FAIL dis_wr_tick e=%0d got=%b exp=%b", e, tick[0], eo);
            end
        end
    endtask

    task automatic test_retune();
        logic eo, et, er;
        load_direct(1, CNT_W'(3));
        step();
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_half  = CNT_W'(9);
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL retune_ready_pre got=%b exp=1", cfg_ready);
        end
        for (int e = 2; e <= 24; e++) begin
            step();
            if (e == 2) cfg_valid = 1'b0;
            eo = (e >= 4 && e <= 13) || (e == 24);
            et = (e == 4) || (e == 24);
            checks++;
            if (clk_out[1] !== eo) begin
                errors++; $display("FAIL retune_clk_out e=%0d got=%b exp=%b", e, clk_out[1], eo);
            end
            checks++;
            if (tick[1] !== et) begin
                errors++; $display("FAIL retune_tick e=%0d got=%b exp=%b", e, tick[1], et);
            end
            if (e <= 4) begin
                #1;
                er = (e == 4);
                checks++;
                if (cfg_ready !== er) begin
                    errors++; $display("FAIL retune_ready e=%0d got=%b exp=%b", e, cfg_ready, er);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic eo, et, er;
        load_direct(2, CNT_W'(2));
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_half  = CNT_W'(4);
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_pre got=%b exp=1", cfg_ready);
        end
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 1) cfg_half = CNT_W'(5);
            if (e == 4) cfg_valid = 1'b0;
            if (e == 19) begin
                cfg_valid = 1'b1;
                cfg_half  = CNT_W'(1);
            end
            if (e == 20) cfg_valid = 1'b0;
            eo = (e >= 3 && e <= 7) || (e >= 14 && e <= 19) || (e >= 26 && e <= 27) || (e >= 30);
            et = (e == 3) || (e == 14) || (e == 26) || (e == 30);
            checks++;
            if (clk_out[2] !== eo) begin
                errors++; $display("FAIL b2b_clk_out e=%0d got=%b exp=%b", e, clk_out[2], eo);
            end
            checks++;
            if (tick[2] !== et) begin
                errors++; $display("FAIL b2b_tick e=%0d got=%b exp=%b", e, tick[2], et);
            end
            if (e <= 4 || e == 8 || e == 19 || e == 20) begin
                #1;
                er = (e == 3) || (e == 8) || (e == 19);
                checks++;
                if (cfg_ready !== er) begin
                    errors++; $display("FAIL b2b_ready e=%0d got=%b exp=%b", e, cfg_ready, er);
                end
            end
        end
    endtask

    task automatic test_enable_disable();
        logic eo, et;
        load_direct(3, CNT_W'(3));
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++;
            if (clk_out[3] !== (e >= 4)) begin
                errors++; $display("FAIL endis_clk_out e=%0d got=%b exp=%b", e, clk_out[3], e >= 4);
            end
        end
        cfg_valid = 1'b1;
        cfg_ch    = 3'd3;
        cfg_half  = CNT_W'(6);
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL endis_ready_pre got=%b exp=1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL endis_ready_pend got=%b exp=0", cfg_ready);
        end
        en[3] = 1'b0;
        step();
        checks++;
        if (clk_out[3] !== 1'b0) begin
            errors++; $display("FAIL endis_drop_clk_out got=%b exp=0", clk_out[3]);
        end
        checks++;
        if (tick[3] !== 1'b0) begin
            errors++; $display("FAIL endis_drop_tick got=%b exp=0", tick[3]);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL endis_drop_ready got=%b exp=1", cfg_ready);
        end
        step();
        en[3] = 1'b1;
        for (int f = 1; f <= 14; f++) begin
            step();
            eo = (f >= 7 && f <= 13);
            et = (f == 7);
            checks++;
            if (clk_out[3] !== eo) begin
                errors++; $display("FAIL endis_re_clk_out f=%0d got=%b exp=%b", f, clk_out[3], eo);
            end
            checks++;
            if (tick[3] !== et) begin
                errors++; $display("FAIL endis_re_tick f=%0d got=%b exp=%b", f, tick[3], et);
            end
        end
    endtask

    task automatic test_async_reset();
        logic eo, et;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_half  = CNT_W'(2);
        step();
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL arst_ready_pend got=%b exp=0", cfg_ready);
        end
        #1;
        clr_n = 1'b0;
        #1;
        checks++;
        if (clk_out !== '0) begin
            errors++; $display("FAIL arst_clk_out got=%b exp=0000", clk_out);
        end
        checks++;
        if (tick !== '0) begin
            errors++; $display("FAIL arst_tick got=%b exp=0000", tick);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL arst_ready got=%b exp=1", cfg_ready);
        end
        en = '1;
        repeat (2) step();
        clr_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            eo = (e % 4 == 2) || (e % 4 == 3);
            et = (e % 4 == 2);
            checks++;
            if (clk_out !== {NCH{eo}}) begin
                errors++; $display("FAIL arst_def_clk_out e=%0d got=%b exp=%b", e, clk_out, {NCH{eo}});
            end
            checks++;
            if (tick !== {NCH{et}}) begin
                errors++; $display("FAIL arst_def_tick e=%0d got=%b exp=%b", e, tick, {NCH{et}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_range();
        test_disabled_write();
        test_retune();
        test_back_to_back();
        test_enable_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
